nco_arbiter: RTL
================

NCO_ARBITER -- requirements
Module: nco_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; PWIDTH, default 23, phase width; SWIDTH, default 18, sample width; NCO_LATENCY, default 10, enabled-cycle latency of the shared nco from i_valid to o_valid.
REQ-002 The block SHALL use one clock, i_clock, and a synchronous active-high reset, i_reset; there are no other clocks or resets.
REQ-003 i_clock  in  1  sole clock, all logic on rising edge.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_enable  in  1  global clock enable, shared with the nco instance.
REQ-006 i_req_phase  in  NREQ*PWIDTH  per-requester signed phase, requester k in bits [k*PWIDTH +: PWIDTH].
REQ-007 i_req_valid  in  NREQ  per-requester phase valid.
REQ-008 o_req_ready  out  NREQ  per-requester accept, at most one bit high.
REQ-009 o_nco_phase  out  PWIDTH  registered phase to nco i_phase.
REQ-010 o_nco_valid  out  1  registered valid to nco i_valid.
REQ-011 i_nco_cosine, i_nco_sine  in  SWIDTH each  nco outputs.
REQ-012 i_nco_valid  in  1  nco o_valid.
REQ-013 o_cosine, o_sine  out  SWIDTH each  registered routed results.
REQ-014 o_valid  out  NREQ  one-hot result strobe naming the owning requester.
REQ-015 o_tag_error  out  1  sticky alignment-error flag.

Function
REQ-016 Transfer rule: requester k SHALL be accepted in a cycle where i_req_valid[k] and o_req_ready[k] are both high.
REQ-017 o_req_ready SHALL be combinational: low for every requester when i_enable is low or i_reset is high.
REQ-018 Otherwise o_req_ready[k] SHALL be high only for the first valid requester found searching upward, with wrap, from priority pointer P.
REQ-019 After an accept of requester k, P SHALL become (k+1) mod NREQ. P SHALL hold on cycles with no accept.
REQ-020 On an enabled cycle, o_nco_phase SHALL load the accepted phase, o_nco_valid SHALL load 1 if an accept occurred and 0 otherwise, and the tag pipeline stage 0 SHALL load {accept, k}.
REQ-021 The tag pipeline SHALL be NCO_LATENCY entries of {valid, index}, shifting only on enabled cycles, so that entry NCO_LATENCY-1 aligns with i_nco_valid.
REQ-022 On an enabled cycle, the output stage SHALL register i_nco_cosine and i_nco_sine into o_cosine and o_sine. o_valid SHALL equal onehot(tail index) when the tail is valid and i_nco_valid is high, and 0 otherwise.
REQ-023 On any cycle with i_enable low, o_valid SHALL be 0; o_cosine, o_sine, o_nco_phase, o_nco_valid, P and the tag pipeline SHALL hold.
REQ-024 End-to-end latency SHALL be exactly NCO_LATENCY+2 enabled cycles, from the accept edge to the o_valid edge. Order SHALL be preserved and there SHALL be no loss or duplication.
REQ-025 Throughput SHALL be one accept per enabled cycle, with no bubbles while any requester is valid.
REQ-026 If, on an enabled cycle, tail valid differs from i_nco_valid, o_tag_error SHALL set and stay high until reset, and o_valid SHALL be 0 for that cycle.
REQ-027 Simultaneous valid from all requesters SHALL be served in strict rotation from P. A requester dropping valid before acceptance SHALL lose nothing.

Reset
REQ-028 On i_reset: P=0, all tag entries invalid, o_nco_valid=0, o_nco_phase=0, o_valid=0, o_cosine=0, o_sine=0, o_tag_error=0. This applies regardless of i_enable.
REQ-029 Reset mid-operation SHALL discard all in-flight tags. The nco instance SHALL be reset by the same i_reset, so no stale result is routed after reset.

Structure
REQ-030 The package nco_pkg SHALL hold NCO_LATENCY_DEFAULT=10, PWIDTH_DEFAULT=23, SWIDTH_DEFAULT=18 and the tag struct typedef {logic valid; logic [$clog2(NREQ)-1:0] idx}.
REQ-031 The round-robin grant logic SHALL be a sub-module, rr_arbiter, parameterised on NREQ, with ports request, advance, grant.
REQ-032 The nco instance SHALL sit outside this block. Integration SHALL tie both blocks to the same i_clock, i_reset and i_enable.

Verification
REQ-033 Single request: reset, then at cycle 5 req0 with phase 0x000000 valid for one cycle -> o_valid=0001 exactly 12 cycles later, with o_cosine equal to the nco cos(0) result.
REQ-034 All four requesters continuously valid -> o_req_ready rotates 0001,0010,0100,1000 repeating; o_valid shows the same sequence delayed 12 cycles.
REQ-035 i_enable toggled 1,0,1,0 with traffic -> no accept while enable is low; latency is 12 enabled cycles; o_valid is never high while enable is low.
REQ-036 Assert i_reset for 1 cycle while 5 results are in flight -> no o_valid afterwards until a new accept, and P=0 (req0 wins the next contention).
REQ-037 Force i_nco_valid=1 with the tag pipeline empty -> o_tag_error=1 the next cycle and held; o_valid=0.
REQ-038 Only req2 valid, with P=0 -> req2 is granted immediately and P becomes 3.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared constants and the tag record that follows each nco request
// through the pipeline so its result can be routed back to the requester.
package nco_pkg;

    localparam int NCO_LATENCY_DEFAULT = 10;
    localparam int PWIDTH_DEFAULT      = 18 + 5;
    localparam int SWIDTH_DEFAULT      = 18;
    localparam int NREQ_DEFAULT        = 4;

    // Index field is sized for up to 256 requesters so one tag type serves
    // every NREQ this block is built with; unused upper bits stay zero.
    localparam int TAG_IDX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first requester at or above the priority pointer,
// searching upward with wrap. The pointer moves past the winner on advance.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [NREQ-1:0] request,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW:0]   cand;
    logic          found;

    // Search upward from the pointer, wrapping at NREQ, for the first request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && request[cand[IW-1:0]]) begin
                grant[cand[IW-1:0]] = 1'b1;
                grant_idx           = cand[IW-1:0];
                found               = 1'b1;
            end
        end
    end

    // Pointer lands just past the winner after an accept, otherwise holds.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            if (grant_idx == IW'(NREQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/nco_arbiter.sv
// Shares one external nco among NREQ requesters. Accepted phases are
// registered toward the nco while a tag pipeline shadows the nco's stages,
// so each result comes back with a one-hot strobe naming its requester.
module nco_arbiter
    import nco_pkg::*;
#(
    parameter  int NREQ        = NREQ_DEFAULT,
    parameter  int PWIDTH      = PWIDTH_DEFAULT,
    parameter  int SWIDTH      = SWIDTH_DEFAULT,
    parameter  int NCO_LATENCY = NCO_LATENCY_DEFAULT,
    localparam int IW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [NREQ*PWIDTH-1:0] i_req_phase,
    input  logic [NREQ-1:0]        i_req_valid,
    output logic [NREQ-1:0]        o_req_ready,
    output logic [PWIDTH-1:0]      o_nco_phase,
    output logic                   o_nco_valid,
    input  logic [SWIDTH-1:0]      i_nco_cosine,
    input  logic [SWIDTH-1:0]      i_nco_sine,
    input  logic                   i_nco_valid,
    output logic [SWIDTH-1:0]      o_cosine,
    output logic [SWIDTH-1:0]      o_sine,
    output logic [NREQ-1:0]        o_valid,
    output logic                   o_tag_error
);

    logic [NREQ-1:0]   req_gated;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     grant_idx;
    logic              accept;
    logic [PWIDTH-1:0] phase_sel;
    logic [NREQ-1:0]   valid_q;

    // Launch tag travels alongside o_nco_valid; the NCO_LATENCY entries
    // behind it mirror the nco's own stages, so the tail meets i_nco_valid.
    tag_t launch_q;
    tag_t pipe_q [NCO_LATENCY];
    tag_t tail;

    assign req_gated   = i_req_valid & {NREQ{i_enable & ~i_reset}};
    assign o_req_ready = grant;
    assign accept      = |grant;
    assign tail        = pipe_q[NCO_LATENCY-1];

    // A held strobe is only shown on enabled cycles so it is seen exactly once.
    assign o_valid     = valid_q & {NREQ{i_enable}};

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .request   (req_gated),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Pick the granted requester's phase; zero when nobody is accepted.
    always_comb begin
        phase_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                phase_sel = i_req_phase[k*PWIDTH +: PWIDTH];
            end
        end
    end

    // Launch register: phase/valid toward the nco plus the matching tag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_nco_phase    <= '0;
            o_nco_valid    <= 1'b0;
            launch_q       <= '0;
        end else if (i_enable) begin
            o_nco_phase    <= phase_sel;
            o_nco_valid    <= accept;
            launch_q.valid <= accept;
            launch_q.idx   <= TAG_IDX_W'(grant_idx);
        end
    end

    // Tag shift register advancing in lockstep with the nco pipeline.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int k = 0; k < NCO_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (i_enable) begin
            pipe_q[0] <= launch_q;
            for (int k = 1; k < NCO_LATENCY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    // Output stage: register nco results, route strobe, flag misalignment.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_cosine    <= '0;
            o_sine      <= '0;
            valid_q     <= '0;
            o_tag_error <= 1'b0;
        end else if (i_enable) begin
            o_cosine <= i_nco_cosine;
            o_sine   <= i_nco_sine;
            if (tail.valid != i_nco_valid) begin
                o_tag_error <= 1'b1;
                valid_q     <= '0;
            end else if (tail.valid) begin
                valid_q <= NREQ'(1) << tail.idx;
            end else begin
                valid_q <= '0;
            end
        end
    end

endmodule
